// File: rtl/ni_vc_flit_buf_pkg.sv
// Shared types and defaults for the NoC virtual-channel flit buffer.
// No ports; provides the flit record, the arbiter state encoding and
// default sizing constants.
package ravenoc_pkg;

    localparam int unsigned NiVcChannels = 2;
    localparam int unsigned NiVcDepth    = 4;
    localparam int unsigned NiVcFlitW    = 34;

    // Flit as stored in a channel FIFO: tail marker above the payload.
    typedef struct packed {
        logic                 last;
        logic [NiVcFlitW-1:0] data;
    } s_vc_flit_t;

    typedef enum logic {
        ARB_IDLE,
        ARB_LOCK
    } arb_state_e;

endpackage

// File: rtl/ni_vc_flit_buf_if.sv
// Handshake bundle of the VC flit buffer.
//   in_*  : per-channel ingress (valid/ready/data/last), N_CH lanes, flat data.
//   out_* : merged egress (valid/ready/data/last) plus source channel.
// slave  : the buffer itself.  master : the producer/consumer around it.
interface ni_vc_flit_buf_if
    import ravenoc_pkg::*;
#(
    parameter int unsigned N_CH   = NiVcChannels,
    parameter int unsigned FLIT_W = NiVcFlitW,
    parameter int unsigned CH_W   = $clog2(N_CH)
) ();

    logic [N_CH-1:0]        in_valid_i;
    logic [N_CH-1:0]        in_ready_o;
    logic [N_CH*FLIT_W-1:0] in_data_i;
    logic [N_CH-1:0]        in_last_i;
    logic                   out_valid_o;
    logic                   out_ready_i;
    logic [FLIT_W-1:0]      out_data_o;
    logic                   out_last_o;
    logic [CH_W-1:0]        out_ch_o;

    modport slave (
        input  in_valid_i, in_data_i, in_last_i, out_ready_i,
        output in_ready_o, out_valid_o, out_data_o, out_last_o, out_ch_o
    );

    modport master (
        output in_valid_i, in_data_i, in_last_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_data_o, out_last_o, out_ch_o
    );

endinterface

// File: rtl/ni_vc_flit_buf_sync_gp_fifo.sv
// Single-clock FIFO with occupancy output.
//   clk/rst              : clock, synchronous active-high reset
//   wr_en_i/wr_data_i    : push (ignored when full)
//   rd_en_i/rd_data_o    : pop (ignored when empty); rd_data_o shows the head
//   full_o/empty_o/fill_o: status
module sync_gp_fifo #(
    parameter int unsigned SLOTS = 4,
    parameter int unsigned WIDTH = 35
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           wr_en_i,
    input  logic [WIDTH-1:0]               wr_data_i,
    output logic                           full_o,
    input  logic                           rd_en_i,
    output logic [WIDTH-1:0]               rd_data_o,
    output logic                           empty_o,
    output logic [$clog2(SLOTS+1)-1:0]     fill_o
);

    localparam int unsigned PTR_W  = $clog2(SLOTS);
    localparam int unsigned FILL_W = $clog2(SLOTS+1);

    logic [WIDTH-1:0]  mem_q [SLOTS];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic              do_wr, do_rd;

    assign full_o    = (fill_q == FILL_W'(SLOTS));
    assign empty_o   = (fill_q == '0);
    assign fill_o    = fill_q;
    assign rd_data_o = mem_q[rd_ptr_q];

    always_comb begin
        do_wr    = wr_en_i && !full_o;
        do_rd    = rd_en_i && !empty_o;
        wr_ptr_d = do_wr ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = do_rd ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        fill_d   = fill_q;
        if (do_wr && !do_rd) begin
            fill_d = fill_q + FILL_W'(1);
        end else if (!do_wr && do_rd) begin
            fill_d = fill_q - FILL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
        end
    end

    // Storage needs no reset: reads are gated by the fill count.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

endmodule

// File: rtl/ni_vc_flit_buf.sv
// Multi-channel flit buffer: one FIFO per VC, merged through a packet-atomic
// round-robin arbiter. Runtime bypass routes inputs straight to the output.
//   clk_noc/arst_noc : clock, synchronous active-high reset
//   bypass_i         : requested mode, applied only when fully idle
//   bus              : ingress/egress handshakes (slave side)
//   fill_o           : per-channel FIFO occupancy, flat
//   mode_o           : mode currently applied (1 = bypass)
module ni_vc_flit_buf
    import ravenoc_pkg::*;
#(
    parameter int unsigned N_CH   = NiVcChannels,
    parameter int unsigned DEPTH  = NiVcDepth,
    parameter int unsigned FLIT_W = NiVcFlitW
) (
    input  logic                                clk_noc,
    input  logic                                arst_noc,
    input  logic                                bypass_i,
    ni_vc_flit_buf_if.slave                     bus,
    output logic [N_CH*$clog2(DEPTH+1)-1:0]     fill_o,
    output logic                                mode_o
);

    localparam int unsigned CH_W   = $clog2(N_CH);
    localparam int unsigned FILL_W = $clog2(DEPTH+1);

    logic [N_CH-1:0] fifo_full, fifo_empty, push, pop, cand;
    logic [FLIT_W:0] fifo_rd [N_CH];
    logic [FLIT_W:0] flit;
    logic            gnt_vld, hs;
    logic [CH_W-1:0] gnt_ch, gnt_next;
    int              idx;

    arb_state_e      state_q, state_d;
    logic [CH_W-1:0] rr_q, rr_d, lock_q, lock_d;
    logic            mode_q, mode_d;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        sync_gp_fifo #(
            .SLOTS (DEPTH),
            .WIDTH (FLIT_W + 1)
        ) u_fifo (
            .clk       (clk_noc),
            .rst       (arst_noc),
            .wr_en_i   (push[c]),
            .wr_data_i ({bus.in_last_i[c], bus.in_data_i[c*FLIT_W +: FLIT_W]}),
            .full_o    (fifo_full[c]),
            .rd_en_i   (pop[c]),
            .rd_data_o (fifo_rd[c]),
            .empty_o   (fifo_empty[c]),
            .fill_o    (fill_o[c*FILL_W +: FILL_W])
        );
    end

    // Grant, output mux and per-channel handshakes.
    always_comb begin
        cand    = mode_q ? bus.in_valid_i : ~fifo_empty;
        gnt_vld = 1'b0;
        gnt_ch  = '0;
        idx     = 0;
        if (state_q == ARB_LOCK) begin
            gnt_vld = cand[lock_q];
            gnt_ch  = lock_q;
        end else begin
            // Walk downward so the candidate closest to rr_q is written last.
            for (int i = int'(N_CH) - 1; i >= 0; i--) begin
                idx = int'(rr_q) + i;
                if (idx >= int'(N_CH)) idx = idx - int'(N_CH);
                if (cand[idx]) begin
                    gnt_vld = 1'b1;
                    gnt_ch  = CH_W'(idx);
                end
            end
        end

        flit = mode_q ? {bus.in_last_i[gnt_ch], bus.in_data_i[gnt_ch*FLIT_W +: FLIT_W]}
                      : fifo_rd[gnt_ch];
        if (!gnt_vld) flit = '0;

        bus.out_valid_o = gnt_vld;
        bus.out_data_o  = flit[FLIT_W-1:0];
        bus.out_last_o  = flit[FLIT_W];
        bus.out_ch_o    = gnt_vld ? gnt_ch : '0;
        hs              = gnt_vld && bus.out_ready_i;

        for (int unsigned c = 0; c < N_CH; c++) begin
            pop[c]            = !mode_q && hs && (gnt_ch == CH_W'(c));
            push[c]           = !mode_q && bus.in_valid_i[c] && !fifo_full[c];
            bus.in_ready_o[c] = mode_q ? (gnt_vld && (gnt_ch == CH_W'(c)) && bus.out_ready_i)
                                       : !fifo_full[c];
        end
    end

    // Arbiter and mode next state.
    always_comb begin
        gnt_next = (gnt_ch == CH_W'(N_CH - 1)) ? '0 : gnt_ch + CH_W'(1);
        state_d  = state_q;
        rr_d     = rr_q;
        lock_d   = lock_q;
        if (hs) begin
            if (flit[FLIT_W]) begin
                state_d = ARB_IDLE;
                rr_d    = gnt_next;
            end else if (state_q == ARB_IDLE) begin
                state_d = ARB_LOCK;
                lock_d  = gnt_ch;
            end
        end
        mode_d = (state_q == ARB_IDLE && (&fifo_empty) && !hs) ? bypass_i : mode_q;
    end

    always_ff @(posedge clk_noc) begin
        if (arst_noc) begin
            state_q <= ARB_IDLE;
            rr_q    <= '0;
            lock_q  <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            lock_q  <= lock_d;
            mode_q  <= mode_d;
        end
    end

    assign mode_o = mode_q;

endmodule

// File: tb/tb_ni_vc_flit_buf.sv
// Self-checking bench for ni_vc_flit_buf: directed scenarios plus randomized
// traffic, checked every cycle against a queue-based reference model.
module tb_ni_vc_flit_buf;

    localparam int unsigned N_CH   = 2;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned FLIT_W = 34;
    localparam int unsigned CH_W   = $clog2(N_CH);
    localparam int unsigned FILL_W = $clog2(DEPTH+1);

    typedef logic [FLIT_W:0] flit_t;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     bypass;
    logic [N_CH*FILL_W-1:0]   fill;
    logic                     mode;

    ni_vc_flit_buf_if #(.N_CH(N_CH), .FLIT_W(FLIT_W)) bus ();

    ni_vc_flit_buf #(
        .N_CH   (N_CH),
        .DEPTH  (DEPTH),
        .FLIT_W (FLIT_W)
    ) dut (
        .clk_noc  (clk),
        .arst_noc (rst),
        .bypass_i (bypass),
        .bus      (bus),
        .fill_o   (fill),
        .mode_o   (mode)
    );

    always #5 clk = ~clk;

    // Stimulus sources, model state and output log.
    flit_t           src [N_CH][$];
    flit_t           mq  [N_CH][$];
    flit_t           got [$];
    logic [CH_W-1:0] got_ch [$];
    bit              vld [N_CH];
    bit              acc [N_CH];
    bit              rnd_valid;
    int              ordy_mode;
    int              rr, lock_ch;
    bit              locked, mmode;
    int              total, passed;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic flit_t mk(input bit last, input logic [FLIT_W-1:0] d);
        return {last, d};
    endfunction

    task automatic drive();
        for (int c = 0; c < N_CH; c++) begin
            if (acc[c]) begin
                void'(src[c].pop_front());
                vld[c] = 1'b0;
                acc[c] = 1'b0;
            end
            if (!vld[c] && src[c].size() > 0 && (!rnd_valid || $urandom_range(0, 1) == 1))
                vld[c] = 1'b1;
            bus.in_valid_i[c] = vld[c];
            {bus.in_last_i[c], bus.in_data_i[c*FLIT_W +: FLIT_W]} = vld[c] ? src[c][0] : '0;
        end
        bus.out_ready_i = (ordy_mode == 2) ? 1'($urandom_range(0, 1)) : (ordy_mode == 1);
    endtask

    // Reference model: evaluates one cycle from the spec's rules, checks the
    // DUT, then advances the model to the state after the next edge.
    task automatic check_update();
        bit    cand [N_CH];
        bit    erdy [N_CH];
        bit    ev, hs, idle_all, ordy;
        int    g;
        flit_t ef;
        ordy = bus.out_ready_i;
        for (int c = 0; c < N_CH; c++) cand[c] = mmode ? vld[c] : (mq[c].size() > 0);
        ev = 1'b0;
        g  = 0;
        if (locked) begin
            ev = cand[lock_ch];
            g  = lock_ch;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                int k = (rr + i) % N_CH;
                if (!ev && cand[k]) begin
                    ev = 1'b1;
                    g  = k;
                end
            end
        end
        ef = !ev ? '0 : (mmode ? src[g][0] : mq[g][0]);
        chk("out_valid", 64'(bus.out_valid_o), 64'(ev));
        chk("out_data", 64'(bus.out_data_o), 64'(ef[FLIT_W-1:0]));
        chk("out_last", 64'(bus.out_last_o), 64'(ef[FLIT_W]));
        chk("out_ch", 64'(bus.out_ch_o), ev ? 64'(g) : 64'd0);
        chk("mode", 64'(mode), 64'(mmode));
        for (int c = 0; c < N_CH; c++) begin
            erdy[c] = mmode ? (ev && g == c && ordy) : (mq[c].size() < DEPTH);
            chk($sformatf("in_ready%0d", c), 64'(bus.in_ready_o[c]), 64'(erdy[c]));
            chk($sformatf("fill%0d", c), 64'(fill[c*FILL_W +: FILL_W]), 64'(mq[c].size()));
        end
        if (bus.out_valid_o && ordy) begin
            got.push_back({bus.out_last_o, bus.out_data_o});
            got_ch.push_back(bus.out_ch_o);
        end
        hs       = ev && ordy;
        idle_all = !locked;
        for (int c = 0; c < N_CH; c++) if (mq[c].size() != 0) idle_all = 1'b0;
        if (hs) begin
            if (!mmode) void'(mq[g].pop_front());
            if (ef[FLIT_W]) begin
                locked = 1'b0;
                rr     = (g + 1) % N_CH;
            end else if (!locked) begin
                locked  = 1'b1;
                lock_ch = g;
            end
        end
        for (int c = 0; c < N_CH; c++) begin
            acc[c] = vld[c] && erdy[c];
            if (!mmode && acc[c]) mq[c].push_back(src[c][0]);
        end
        if (idle_all && !hs) mmode = bypass;
    endtask

    task automatic step();
        @(negedge clk);
        check_update();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        for (int c = 0; c < N_CH; c++) begin
            vld[c] = 1'b0;
            acc[c] = 1'b0;
            src[c].delete();
            mq[c].delete();
        end
        drive();
        repeat (n) @(posedge clk);
        #1;
        rst     = 1'b0;
        rr      = 0;
        lock_ch = 0;
        locked  = 1'b0;
        mmode   = 1'b0;
        got.delete();
        got_ch.delete();
    endtask

    // Both channels load a 2-flit packet while the output stalls, then drain.
    task automatic contend(input logic [FLIT_W-1:0] b0, input logic [FLIT_W-1:0] b1);
        got.delete();
        got_ch.delete();
        ordy_mode = 0;
        src[0].push_back(mk(0, b0));
        src[0].push_back(mk(1, b0 + 1));
        src[1].push_back(mk(0, b1));
        src[1].push_back(mk(1, b1 + 1));
        drive();
        repeat (3) step();
        ordy_mode = 1;
        drive();
        repeat (6) step();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        total     = 0;
        passed    = 0;
        bypass    = 1'b0;
        rnd_valid = 1'b0;
        ordy_mode = 1;
        do_reset(3);

        // Reset state
        chk("rst_out_valid", 64'(bus.out_valid_o), 64'd0);
        chk("rst_fill", 64'(fill), 64'd0);
        chk("rst_mode", 64'(mode), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready_o), 64'h3);
        chk("rst_out_data", 64'(bus.out_data_o), 64'd0);

        // Single buffered packet on ch0
        src[0].push_back(mk(0, 34'hA1));
        src[0].push_back(mk(0, 34'hA2));
        src[0].push_back(mk(1, 34'hA3));
        drive();
        repeat (5) step();
        chk("pkt_count", 64'(got.size()), 64'd3);
        for (int i = 0; i < 3 && i < got.size(); i++) begin
            chk("pkt_flit", 64'(got[i]), 64'(mk(i == 2, 34'hA1 + i)));
            chk("pkt_ch", 64'(got_ch[i]), 64'd0);
        end

        // Fill and backpressure on ch1
        got.delete();
        got_ch.delete();
        ordy_mode = 0;
        for (int i = 0; i < 5; i++) src[1].push_back(mk(i == 4, 34'hB1 + i));
        drive();
        repeat (6) step();
        chk("bp_fill1", 64'(fill[FILL_W +: FILL_W]), 64'd4);
        chk("bp_ready1", 64'(bus.in_ready_o[1]), 64'd0);
        ordy_mode = 1;
        drive();
        repeat (8) step();
        chk("bp_count", 64'(got.size()), 64'd5);
        for (int i = 0; i < 5 && i < got.size(); i++)
            chk("bp_order", 64'(got[i]), 64'(mk(i == 4, 34'hB1 + i)));
        chk("bp_ready1_back", 64'(bus.in_ready_o[1]), 64'd1);

        // Packet atomicity and round-robin
        contend(34'hC1, 34'hD1);
        chk("rr_count", 64'(got.size()), 64'd4);
        if (got.size() == 4) begin
            chk("rr_f0", 64'(got[0]), 64'(mk(0, 34'hC1)));
            chk("rr_f1", 64'(got[1]), 64'(mk(1, 34'hC2)));
            chk("rr_f2", 64'(got[2]), 64'(mk(0, 34'hD1)));
            chk("rr_f3", 64'(got[3]), 64'(mk(1, 34'hD2)));
        end
        contend(34'hE1, 34'hF1);
        chk("rr_wrap_first_ch", got_ch.size() > 0 ? 64'(got_ch[0]) : 64'hDEAD, 64'd0);

        // Mode change waits for idle
        got.delete();
        got_ch.delete();
        ordy_mode = 0;
        src[0].push_back(mk(0, 34'h11));
        src[0].push_back(mk(1, 34'h12));
        drive();
        repeat (3) step();
        bypass = 1'b1;
        repeat (2) step();
        chk("mode_pending", 64'(mode), 64'd0);
        ordy_mode = 1;
        drive();
        repeat (4) step();
        chk("mode_applied", 64'(mode), 64'd1);
        src[1].push_back(mk(1, 34'h2_0000_0F1));
        drive();
        #1;
        chk("byp_valid", 64'(bus.out_valid_o), 64'd1);
        chk("byp_data", 64'(bus.out_data_o), 64'h2_0000_0F1);
        chk("byp_ch", 64'(bus.out_ch_o), 64'd1);
        repeat (2) step();
        bypass = 1'b0;
        repeat (2) step();
        chk("mode_back", 64'(mode), 64'd0);

        // Reset mid-packet
        got.delete();
        got_ch.delete();
        src[0].push_back(mk(0, 34'h31));
        src[0].push_back(mk(0, 34'h32));
        src[0].push_back(mk(1, 34'h33));
        drive();
        for (int i = 0; i < 10 && got.size() == 0; i++) step();
        chk("mid_first_out", 64'(got.size()), 64'd1);
        do_reset(1);
        chk("mid_fill", 64'(fill), 64'd0);
        chk("mid_valid", 64'(bus.out_valid_o), 64'd0);
        src[1].push_back(mk(1, 34'h41));
        drive();
        repeat (2) step();
        chk("mid_ch1_count", 64'(got.size()), 64'd1);
        if (got.size() == 1) begin
            chk("mid_ch1_ch", 64'(got_ch[0]), 64'd1);
            chk("mid_ch1_data", 64'(got[0]), 64'(mk(1, 34'h41)));
        end

        // Randomized traffic: buffered, then bypass
        for (int ph = 0; ph < 2; ph++) begin
            bypass = (ph == 1);
            repeat (3) step();
            chk("rnd_mode", 64'(mode), 64'(ph));
            rnd_valid = 1'b1;
            ordy_mode = 2;
            for (int n = 0; n < 300; n++) begin
                for (int c = 0; c < N_CH; c++) begin
                    if (src[c].size() == 0) begin
                        int len = $urandom_range(1, 4);
                        for (int j = 0; j < len; j++)
                            src[c].push_back(mk(j == len - 1, FLIT_W'({$urandom, $urandom})));
                    end
                end
                step();
            end
            rnd_valid = 1'b0;
            ordy_mode = 1;
            drive();
            repeat (40) step();
            chk("rnd_drained", 64'(fill), 64'd0);
        end
        bypass = 1'b0;
        repeat (3) step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
